seq_signed_comparator: RTL and testbench

- Parametrised, chunk-serial magnitude comparator. Successor to the fixed 32-bit combinational signed less-than comparator.
- Compares two WIDTH-bit operands, most-significant chunk first, CHUNK bits per cycle.
- Runtime signed/unsigned mode and a 3-bit relational-op select.
- Valid/ready handshakes on both sides; sits in crypto datapaths where a narrow per-cycle compare meets timing and saves area.

---
 rtl/seq_signed_comparator_if.sv | 30 +++
 rtl/seq_signed_comparator.sv | 146 ++++++++++++++
 tb/tb_seq_signed_comparator.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/seq_signed_comparator_if.sv
// Handshake bundle for seq_signed_comparator: operand/op request side and result side.
// Latency: none, wires only.
// Backpressure: in_valid/in_ready on the request side, out_valid/out_ready on the result side.
interface seq_signed_comparator_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             signed_mode;
  logic [2:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic             result;
  logic             a_lt_b;
  logic             a_eq_b;

  // Producer of operands and consumer of results.
  modport master (
    output in_valid, a, b, signed_mode, op, out_ready,
    input  in_ready, out_valid, result, a_lt_b, a_eq_b
  );

  // The comparator itself.
  modport slave (
    input  in_valid, a, b, signed_mode, op, out_ready,
    output in_ready, out_valid, result, a_lt_b, a_eq_b
  );
endinterface

// File: rtl/seq_signed_comparator.sv
// Chunk-serial signed/unsigned magnitude comparator, MSB chunk first, CHUNK bits per cycle.
// Latency: handshake edge t -> out_valid sampled high at edge t+N+1 (N = WIDTH/CHUNK).
// Backpressure: one op in flight; result held in DONE until out_ready, in_ready only in IDLE.
// Optional macro SEQ_CMP_EARLY_EXIT_EN: leave BUSY as soon as a chunk differs.
module seq_signed_comparator #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  seq_signed_comparator_if.slave bus
);

  localparam int N  = WIDTH / CHUNK;
  localparam int IW = $clog2(N) + 1;
  localparam logic [IW-1:0] MSB_IDX = IW'(N - 1);

  localparam logic [2:0] OP_LT = 3'd0;
  localparam logic [2:0] OP_LE = 3'd1;
  localparam logic [2:0] OP_GT = 3'd2;
  localparam logic [2:0] OP_GE = 3'd3;
  localparam logic [2:0] OP_EQ = 3'd4;
  localparam logic [2:0] OP_NE = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             sm_q;
  logic [2:0]       op_q;
  logic             lt_q;
  logic             gt_q;
  logic [IW-1:0]    idx_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             result_q;
  logic             a_lt_b_q;
  logic             a_eq_b_q;

  logic [CHUNK-1:0] ca;
  logic [CHUNK-1:0] cb;
  logic             lt_d;
  logic             gt_d;
  logic             eq_d;
  logic             result_d;
  logic             finish_d;

  // Compare the current top chunk and fold it into the sticky lt/gt flags.
  always_comb begin
    ca = a_q[WIDTH-1 -: CHUNK];
    cb = b_q[WIDTH-1 -: CHUNK];
    // Flipping the sign bit of the MSB chunk maps two's-complement order onto unsigned order.
    if (sm_q && (idx_q == MSB_IDX)) begin
      ca[CHUNK-1] = ~ca[CHUNK-1];
      cb[CHUNK-1] = ~cb[CHUNK-1];
    end
    lt_d = lt_q | (~(lt_q | gt_q) & (ca < cb));
    gt_d = gt_q | (~(lt_q | gt_q) & (ca > cb));
    eq_d = ~lt_d & ~gt_d;
`ifdef SEQ_CMP_EARLY_EXIT_EN
    finish_d = (idx_q == '0) | lt_d | gt_d;
`else
    finish_d = (idx_q == '0);
`endif
    case (op_q)
      OP_LT:   result_d = lt_d;
      OP_LE:   result_d = lt_d | eq_d;
      OP_GT:   result_d = gt_d;
      OP_GE:   result_d = gt_d | eq_d;
      OP_EQ:   result_d = eq_d;
      OP_NE:   result_d = ~eq_d;
      default: result_d = 1'b0;
    endcase
  end

  // Control FSM: latch request, walk chunks MSB-first by shifting, hold result until accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= 1'b0;
      a_lt_b_q    <= 1'b0;
      a_eq_b_q    <= 1'b0;
      lt_q        <= 1'b0;
      gt_q        <= 1'b0;
      idx_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            a_q        <= bus.a;
            b_q        <= bus.b;
            sm_q       <= bus.signed_mode;
            op_q       <= bus.op;
            lt_q       <= 1'b0;
            gt_q       <= 1'b0;
            idx_q      <= MSB_IDX;
            in_ready_q <= 1'b0;
            state_q    <= BUSY;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        BUSY: begin
          lt_q  <= lt_d;
          gt_q  <= gt_d;
          a_q   <= a_q << CHUNK;
          b_q   <= b_q << CHUNK;
          idx_q <= idx_q - IW'(1);
          if (finish_d) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            result_q    <= result_d;
            a_lt_b_q    <= lt_d;
            a_eq_b_q    <= eq_d;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.a_lt_b    = a_lt_b_q;
  assign bus.a_eq_b    = a_eq_b_q;

endmodule

// File: tb/tb_seq_signed_comparator.sv
// Bench for seq_signed_comparator (WIDTH=32, CHUNK=8): directed plan cases plus random ops.
// Expected values come from a plain-arithmetic model of the relational ops and latency.
// Honours SEQ_CMP_EARLY_EXIT_EN for the expected latency only; results are build-independent.
module tb_seq_signed_comparator;
  localparam int WIDTH = 32;
  localparam int CHUNK = 8;
  localparam int N     = WIDTH / CHUNK;

  logic clk = 1'b0;
  logic rst;
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  seq_signed_comparator_if #(.WIDTH(WIDTH)) bus ();

  seq_signed_comparator #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Relational reference from integer arithmetic.
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic sm,
                                input logic [2:0] op, output logic lt, output logic eq,
                                output logic res);
    logic gt;
    if (sm) lt = ($signed(a) < $signed(b));
    else    lt = (a < b);
    eq = (a == b);
    gt = !lt && !eq;
    case (op)
      3'd0:    res = lt;
      3'd1:    res = lt || eq;
      3'd2:    res = gt;
      3'd3:    res = gt || eq;
      3'd4:    res = eq;
      3'd5:    res = !eq;
      default: res = 1'b0;
    endcase
  endfunction

  function automatic int exp_latency(input logic [31:0] a, input logic [31:0] b);
    int lat;
    lat = N + 1;
`ifdef SEQ_CMP_EARLY_EXIT_EN
    for (int i = N - 1; i >= 0; i--) begin
      if (a[i*CHUNK +: CHUNK] != b[i*CHUNK +: CHUNK]) begin
        lat = (N - i) + 1;
        break;
      end
    end
`endif
    return lat;
  endfunction

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  // Handshake on the next edge, then scramble inputs to show the latched copies are used.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic sm,
                          input logic [2:0] op);
    bus.a           = a;
    bus.b           = b;
    bus.signed_mode = sm;
    bus.op          = op;
    bus.in_valid    = 1'b1;
    @(posedge clk); #1;
    bus.in_valid    = 1'b0;
    bus.a           = $urandom;
    bus.b           = $urandom;
    bus.signed_mode = 1'($urandom);
    bus.op          = 3'($urandom);
  endtask

  // Latency = edges from handshake to the first edge that samples out_valid high.
  task automatic await_valid(output int lat);
    int n;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    lat = n + 1;
  endtask

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic sm,
                       input logic [2:0] op, input string tag);
    logic lt, eq, res;
    int   lat;
    wait_ready(tag);
    start_op(a, b, sm, op);
    await_valid(lat);
    model(a, b, sm, op, lt, eq, res);
    check({tag, ".latency"}, 32'(lat), 32'(exp_latency(a, b)));
    check({tag, ".result"}, 32'(bus.result), 32'(res));
    check({tag, ".a_lt_b"}, 32'(bus.a_lt_b), 32'(lt));
    check({tag, ".a_eq_b"}, 32'(bus.a_eq_b), 32'(eq));
    @(posedge clk); #1;
    check({tag, ".vld_drop"}, 32'(bus.out_valid), 32'd0);
    check({tag, ".rdy_back"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        lt, eq, res;
    int          lat;
    logic [31:0] ra, rb;
    logic        hold_res, hold_lt, hold_eq;

    bus.in_valid    = 1'b0;
    bus.a           = '0;
    bus.b           = '0;
    bus.signed_mode = 1'b0;
    bus.op          = 3'd0;
    bus.out_ready   = 1'b1;
    rst             = 1'b1;
    bus.in_valid    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst.in_ready", 32'(bus.in_ready), 32'd0);
    check("rst.out_valid", 32'(bus.out_valid), 32'd0);
    check("rst.result", 32'(bus.result), 32'd0);
    check("rst.a_lt_b", 32'(bus.a_lt_b), 32'd0);
    check("rst.a_eq_b", 32'(bus.a_eq_b), 32'd0);
    bus.in_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst.in_ready", 32'(bus.in_ready), 32'd1);

    // Directed plan cases.
    do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 3'd0, "s_lt");
    do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 3'd0, "u_lt");
    do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 3'd3, "u_ge");
    do_op(32'h1234_5678, 32'h1234_5678, 1'b1, 3'd4, "eq_eq");
    do_op(32'h1234_5678, 32'h1234_5678, 1'b1, 3'd1, "eq_le");
    do_op(32'h1234_5678, 32'h1234_5678, 1'b0, 3'd3, "eq_ge");
    do_op(32'h1234_5678, 32'h1234_5678, 1'b0, 3'd5, "eq_ne");
    do_op(32'h1234_5678, 32'h1234_5678, 1'b1, 3'd6, "eq_op6");
    do_op(32'h8000_0000, 32'h0000_0000, 1'b1, 3'd0, "ee_msb");
    do_op(32'h0000_0001, 32'h0000_0002, 1'b1, 3'd0, "ee_lsb");
    do_op(32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 3'd2, "s_gt_sign");
    do_op(32'h0000_0080, 32'h0000_0000, 1'b1, 3'd0, "s_inner_top");
    do_op(32'h0000_0000, 32'h8000_0000, 1'b0, 3'd0, "u_msb");

    // Backpressure: result must hold while out_ready is low.
    bus.out_ready = 1'b0;
    wait_ready("hold");
    start_op(32'hFFFF_FF00, 32'h0000_0020, 1'b1, 3'd1);
    await_valid(lat);
    model(32'hFFFF_FF00, 32'h0000_0020, 1'b1, 3'd1, lt, eq, res);
    check("hold.latency", 32'(lat), 32'(exp_latency(32'hFFFF_FF00, 32'h0000_0020)));
    check("hold.result", 32'(bus.result), 32'(res));
    hold_res = bus.result;
    hold_lt  = bus.a_lt_b;
    hold_eq  = bus.a_eq_b;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("hold.out_valid", 32'(bus.out_valid), 32'd1);
      check("hold.result_stable", 32'(bus.result), 32'(hold_res));
      check("hold.a_lt_b_stable", 32'(bus.a_lt_b), 32'(hold_lt));
      check("hold.a_eq_b_stable", 32'(bus.a_eq_b), 32'(hold_eq));
      check("hold.in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("hold.release_vld", 32'(bus.out_valid), 32'd0);
    check("hold.release_rdy", 32'(bus.in_ready), 32'd1);

    // Reset two cycles into BUSY discards the operation.
    wait_ready("midrst");
    start_op(32'h0000_0001, 32'h0000_0002, 1'b0, 3'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst.out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst.in_ready", 32'(bus.in_ready), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("midrst.in_ready_back", 32'(bus.in_ready), 32'd1);
    for (int i = 0; i < N + 2; i++) begin
      @(posedge clk); #1;
      check("midrst.no_stale", 32'(bus.out_valid), 32'd0);
    end
    do_op(32'h8765_4321, 32'h8765_4322, 1'b1, 3'd2, "midrst.fresh");

    // Random ops against the model, biased towards equal and near-equal operands.
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = ra ^ (32'd1 << $urandom_range(0, 31));
        default: rb = $urandom;
      endcase
      do_op(ra, rb, 1'($urandom), 3'($urandom), "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
